// File: rtl/dma_bus_ctrl.sv
// Memory-bus controller sharing one 64 KiB port between the CPU and a 256-byte page-copy DMA.
// Optional DMA_ALIGN_EN: inserts an ALIGN cycle so the copy phase follows a free-running parity.
module dma_bus_ctrl #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
`ifdef DMA_ALIGN_EN
    ST_ALIGN = 3'd5,
`endif
    ST_DONE  = 3'd4
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [7:0]  page_r;
  logic [7:0]  offset_r;
  logic        trig_s;
  logic        last_s;

  assign cpu_rdata = mem_rdata;
  assign trig_s    = cpu_we && (cpu_addr == TRIG_ADDR);
  assign last_s    = (offset_r == 8'hFF);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Source page and byte offset; offset never carries into the page
  always_ff @(posedge clk) begin
    if (reset) begin
      page_r   <= 8'h00;
      offset_r <= 8'h00;
    end else if ((state_r == ST_IDLE) && trig_s) begin
      page_r   <= cpu_wdata;
      offset_r <= 8'h00;
    end else if ((state_r == ST_WRITE) && !last_s) begin
      offset_r <= offset_r + 8'd1;
    end else begin
      page_r   <= page_r;
      offset_r <= offset_r;
    end
  end

`ifdef DMA_ALIGN_EN
  logic parity_r;

  // Free-running cycle parity used to align the copy phase
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_r <= 1'b0;
    end else begin
      parity_r <= ~parity_r;
    end
  end
`endif

  // Next-state logic; CPU inputs only matter in IDLE
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (trig_s) begin
          next_state_s = ST_HALT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_HALT: begin
`ifdef DMA_ALIGN_EN
        if (parity_r) begin
          next_state_s = ST_ALIGN;
        end else begin
          next_state_s = ST_READ;
        end
`else
        next_state_s = ST_READ;
`endif
      end
`ifdef DMA_ALIGN_EN
      ST_ALIGN: next_state_s = ST_READ;
`endif
      ST_READ:  next_state_s = ST_WRITE;
      ST_WRITE: begin
        if (last_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_READ;
        end
      end
      ST_DONE:  next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // Output decode; the trigger write itself is swallowed, never forwarded to memory
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    cpu_rdy   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cpu_rdy = 1'b1;
        busy    = 1'b0;
        mem_we  = cpu_we && !trig_s;
      end
      ST_HALT, ST_READ: begin
        mem_addr  = {page_r, offset_r};
        mem_wdata = 8'h00;
      end
`ifdef DMA_ALIGN_EN
      ST_ALIGN: begin
        mem_addr  = {page_r, offset_r};
        mem_wdata = 8'h00;
      end
`endif
      ST_WRITE: begin
        mem_addr  = DEST_ADDR;
        mem_wdata = mem_rdata;
        mem_we    = 1'b1;
      end
      ST_DONE: begin
        mem_addr  = {page_r, offset_r};
        mem_wdata = 8'h00;
        done      = 1'b1;
      end
      default: begin
        cpu_rdy = 1'b1;
        busy    = 1'b0;
        mem_we  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dma_bus_ctrl.sv
// Directed bench for dma_bus_ctrl: pass-through, full copy, page wrap, retrigger and reset abort.
module tb_dma_bus_ctrl;
  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] DEST = 16'h2004;
`ifdef DMA_ALIGN_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = 16'h1234;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata = 8'h00;
  logic        busy;
  logic        done;

  logic [7:0]  mem [0:65535];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic        par_m = 1'b0;

  logic [7:0]  wr_q[$];
  logic [15:0] src_q[$];
  int          done_n, done_cyc, rise_cyc, rdy_low;
  bit          saw_zero;
  logic [15:0] prev_addr = 16'h0000;
  logic        prev_rdy = 1'b1;

  dma_bus_ctrl #(.TRIG_ADDR(TRIG), .DEST_ADDR(DEST)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous memory model and reference cycle/parity counters
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    par_m <= reset ? 1'b0 : ~par_m;
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Bus monitor: DEST writes with their source address, done pulses, CPU stall length
  always @(negedge clk) begin
    if (mem_we && mem_addr == DEST) begin
      wr_q.push_back(mem_wdata);
      src_q.push_back(prev_addr);
    end
    if (done) begin
      done_n   = done_n + 1;
      done_cyc = cyc;
    end
    if (busy && mem_addr == 16'h0000) saw_zero = 1'b1;
    if (!cpu_rdy) rdy_low = rdy_low + 1;
    if (cpu_rdy && !prev_rdy) rise_cyc = cyc;
    prev_rdy  = cpu_rdy;
    prev_addr = mem_addr;
  end

  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  task clear_mon;
    wr_q.delete();
    src_q.delete();
    done_n   = 0;
    done_cyc = -1;
    rise_cyc = -1;
    rdy_low  = 0;
    saw_zero = 1'b0;
  endtask

  // Drive the trigger write in cycle T and return T plus the expected alignment stall
  task trigger(input logic [7:0] pg, output int t, output int extra);
    cpu_addr  = TRIG;
    cpu_wdata = pg;
    cpu_we    = 1'b1;
    clear_mon();
    #2;
    check("trig_we", mem_we, 1'b0);
    check("trig_rdy", cpu_rdy, 1'b1);
    t = cyc;
    tick;
    cpu_we   = 1'b0;
    cpu_addr = 16'h1234;
    extra = (ALIGN_ON && par_m) ? 1 : 0;
  endtask

  task wait_done(input string nm, input int t, input int extra);
    int n;
    n = 0;
    while ((done_n == 0 || !cpu_rdy) && n < 800) begin
      tick;
      n++;
    end
    tick;
    check({nm, "_timeout"}, (n < 800), 1'b1);
    check({nm, "_done_cyc"}, done_cyc, t + 514 + extra);
    check({nm, "_rdy_cyc"}, rise_cyc, t + 515 + extra);
    check({nm, "_rdy_low"}, rdy_low, 514 + extra);
    check({nm, "_done_n"}, done_n, 1);
    check({nm, "_nwr"}, wr_q.size(), 256);
  endtask

  task check_data(input string nm, input logic [7:0] pg, input logic [7:0] xv);
    logic [7:0] b;
    if (wr_q.size() == 256) begin
      for (int i = 0; i < 256; i++) begin
        b = i[7:0];
        check({nm, "_data"}, wr_q[i], b ^ xv);
        check({nm, "_src"}, src_q[i], {pg, b});
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t, ex;
    logic [7:0] b;
    for (int i = 0; i < 65536; i++) begin
      b = i[7:0];
      mem[i] = b ^ 8'h11;
    end
    for (int i = 0; i < 256; i++) begin
      b = i[7:0];
      mem[16'h0300 + i] = b ^ 8'hA5;
      mem[16'hFF00 + i] = b ^ 8'h3C;
    end

    reset = 1'b1;
    repeat (3) tick;
    reset = 1'b0;
    tick;
    check("rst_rdy", cpu_rdy, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 16'h1234);

    cpu_addr  = 16'h0200;
    cpu_wdata = 8'h5A;
    cpu_we    = 1'b1;
    #2;
    check("pt_we", mem_we, 1'b1);
    check("pt_addr", mem_addr, 16'h0200);
    check("pt_wdata", mem_wdata, 8'h5A);
    check("pt_rdy", cpu_rdy, 1'b1);
    tick;
    cpu_we   = 1'b0;
    cpu_addr = 16'h1234;
    tick;

    trigger(8'h03, t, ex);
    check("copy_busy", busy, 1'b1);
    check("copy_halt_rdy", cpu_rdy, 1'b0);
    wait_done("copy", t, ex);
    check_data("copy", 8'h03, 8'hA5);

    trigger(8'hFF, t, ex);
    wait_done("wrap", t, ex);
    check_data("wrap", 8'hFF, 8'h3C);
    check("wrap_last_src", (src_q.size() > 0) ? src_q[src_q.size()-1] : 16'h0000, 16'hFFFF);
    check("wrap_zero", saw_zero, 1'b0);

    trigger(8'h03, t, ex);
    repeat (99) tick;
    cpu_addr  = TRIG;
    cpu_wdata = 8'h07;
    cpu_we    = 1'b1;
    #2;
    check("retrig_busy", busy, 1'b1);
    check("retrig_rdy", cpu_rdy, 1'b0);
    tick;
    cpu_we   = 1'b0;
    cpu_addr = 16'h1234;
    wait_done("retrig", t, ex);
    check_data("retrig", 8'h03, 8'hA5);
    repeat (10) tick;
    check("retrig_no_second", done_n, 1);

    trigger(8'h03, t, ex);
    repeat (199) tick;
    check("abort_at", cyc, t + 200);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #2;
    check("abort_busy", busy, 1'b0);
    check("abort_rdy", cpu_rdy, 1'b1);
    check("abort_we", mem_we, 1'b0);
    check("abort_nwr", wr_q.size(), 99);
    repeat (20) tick;
    check("abort_nwr_after", wr_q.size(), 99);
    check("abort_done", done_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
